// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared mode codes, frame sizing and controller states for the badge UART command initiator
package uart_cmd_pkg;
  localparam logic [7:0] MODE_SEND_TX        = 8'd64;
  localparam logic [7:0] MODE_SHOOTING_FLAGS = 8'd65;
  localparam logic [7:0] MODE_AES_KEY        = 8'd66;
  localparam logic [7:0] MODE_AES_PT         = 8'd67;
  localparam int DEF_MAX_PAYLOAD = 16;
  localparam int FRAME_BYTES_MAX = DEF_MAX_PAYLOAD + 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_FIN
  } state_t;
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serialiser with a 16x oversampled baud counter and a registered tx line
module uart_byte_tx #(
  parameter int BR_LIMIT = 672,
  parameter int BR_BITS  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] data,
  output logic       bit_end,
  output logic [3:0] bit_idx,
  output logic       byte_done,
  output logic       tx
);
  logic [BR_BITS-1:0] br_cnt;
  logic [3:0] tick_cnt;
  logic [7:0] shreg;
  logic active;
  logic tick;
  logic cur_bit;
  assign tick = br_cnt == BR_BITS'(BR_LIMIT - 1);
  assign bit_end = tick && tick_cnt == 4'd15;
  assign byte_done = active && bit_end && bit_idx == 4'd9;
  assign cur_bit = bit_idx == 4'd0 ? 1'b0 : bit_idx == 4'd9 ? 1'b1 : shreg[0];
  // tx trails the bit counters by one clock, so every bit keeps its full width
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      br_cnt   <= '0;
      tick_cnt <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      active   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      br_cnt   <= (!en || tick) ? '0 : br_cnt + 1'b1;
      tick_cnt <= !en ? '0 : tick ? tick_cnt + 4'd1 : tick_cnt;
      tx       <= active ? cur_bit : 1'b1;
      if (start) begin
        shreg   <= data;
        bit_idx <= '0;
        active  <= 1'b1;
      end else if (active && bit_end) begin
        shreg   <= bit_idx == 4'd0 ? shreg : shreg >> 1;
        bit_idx <= byte_done ? 4'd0 : bit_idx + 4'd1;
        active  <= !byte_done;
      end
    end
endmodule

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: frames a command as mode, payload (highest byte first), mode and sends it 8N1 on tx
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
  parameter int BR_LIMIT    = 672,
  parameter int BR_BITS     = 10,
  parameter int GAP_BITS    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_mode,
  input  logic [4:0]               cmd_len,
  input  logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic                     tx,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int SW = $clog2(8 * MAX_PAYLOAD);
  state_t state, state_nxt;
  logic [7:0] mode_r;
  logic [4:0] len_r;
  logic [8*MAX_PAYLOAD-1:0] payload_r;
  logic [4:0] idx, idx_nxt, nxt;
  logic [7:0] gap_cnt;
  logic [SW-1:0] sel;
  logic [7:0] byte_data;
  logic [3:0] bit_idx;
  logic accept, bad_len, start, bit_end, byte_done;
  assign cmd_ready = state == S_IDLE && !done && !err;
  assign busy = state != S_IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign bad_len = cmd_len == 5'd0 || int'(cmd_len) > MAX_PAYLOAD;
  // byte fed to the serialiser on a start strobe: mode at both ends, payload byte nxt in between
  assign nxt = idx - 5'd1;
  assign sel = SW'({nxt - 5'd1, 3'b000});
  assign byte_data = state == S_LOAD || nxt == 5'd0 ? mode_r : payload_r[sel +: 8];
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    start = 1'b0;
    case (state)
      S_IDLE: state_nxt = accept && !bad_len ? S_LOAD : S_IDLE;
      S_LOAD: begin
        state_nxt = S_START;
        idx_nxt = len_r + 5'd1;
        start = 1'b1;
      end
      S_START: state_nxt = bit_end ? S_DATA : S_START;
      S_DATA: state_nxt = bit_end && bit_idx == 4'd8 ? S_STOP : S_DATA;
      S_STOP: if (byte_done) begin
        state_nxt = idx == 5'd0 ? S_GAP : S_START;
        idx_nxt = idx == 5'd0 ? idx : nxt;
        start = idx != 5'd0;
      end
      S_GAP: state_nxt = bit_end && gap_cnt == 8'(GAP_BITS - 1) ? S_FIN : S_GAP;
      S_FIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      mode_r    <= '0;
      len_r     <= '0;
      payload_r <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gap_cnt <= state != S_GAP ? '0 : gap_cnt + {7'd0, bit_end};
      err     <= accept && bad_len;
      done    <= state == S_FIN;
      if (accept) begin
        mode_r    <= cmd_mode;
        len_r     <= cmd_len;
        payload_r <= cmd_payload;
      end
    end
  uart_byte_tx #(
    .BR_LIMIT(BR_LIMIT),
    .BR_BITS (BR_BITS)
  ) u_byte (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state != S_IDLE && state != S_LOAD),
    .start    (start),
    .data     (byte_data),
    .bit_end  (bit_end),
    .bit_idx  (bit_idx),
    .byte_done(byte_done),
    .tx       (tx)
  );
endmodule

// File: doc/uart_cmd_tx.md
Name: uart_cmd_tx

Overview:
- Initiator side of the badge UART command protocol. It turns one command request into a framed byte sequence and serialises it 8N1 on a single tx line.
- The frame layout is mode byte, payload bytes, mode byte (end-char check). This is the layout the badge command parser consumes on interconnect[0].
- Used by a controller/peer badge to drive modes "@", "A", "B" and "C" (send-TX, shooting flags, AES key, AES plaintext) without host software.

Parameters:
- MAX_PAYLOAD, 16, maximum payload bytes per frame; frame length = len+2.
- BR_LIMIT, 672, clocks per baud tick; one bit = 16 ticks (16x oversample convention).
- BR_BITS, 10, width of the baud tick counter; must hold BR_LIMIT-1.
- GAP_BITS, 2, idle (mark) bit-times forced after each frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request; held until accepted.
- cmd_ready  out  1  high in IDLE only; accept = cmd_valid & cmd_ready.
- cmd_mode  in  8  mode byte, sent first and last.
- cmd_len  in  5  payload byte count, legal 1..MAX_PAYLOAD.
- cmd_payload  in  8*MAX_PAYLOAD  payload; byte k (1-based) = bits [8k-1:8k-8].
- tx  out  1  serial line, idle high.
- busy  out  1  high from accept until GAP ends.
- done  out  1  one-cycle pulse when GAP ends.
- err  out  1  one-cycle pulse on an accepted illegal cmd_len.

Behaviour:
- Reset (async, any state): tx=1, cmd_ready=1, busy=0, done=0, err=0, state=IDLE, counters 0. A frame in progress is abandoned; tx returns high immediately.
- Accept:
  - cmd_mode, cmd_len and cmd_payload are registered on the accept edge; later input changes are ignored.
  - cmd_ready drops the next cycle.
- Illegal length:
  - cmd_len==0 or cmd_len>MAX_PAYLOAD: err pulses the cycle after accept.
  - No frame is sent; state stays IDLE and cmd_ready returns to 1 after that cycle.
- Frame bytes: N=len+2 bytes B[N-1..0]; B[N-1]=B[0]=mode; B[k]=payload byte k for 1<=k<=len. Bytes are sent B[N-1] first, down to B[0], so the receiver's shift register ends with mode in its low byte.
- Byte serialisation: start bit 0, data LSB first, stop bit 1. Each bit lasts exactly 16*BR_LIMIT clocks. Consecutive bytes of a frame are back-to-back with no extra idle.
- FSM:
  - IDLE: on legal accept -> LOAD.
  - LOAD (1 cycle): set byte index = N-1 -> START.
  - START -> DATA (8 bits) -> STOP.
  - STOP end: if index==0 -> GAP, else index-1 -> START.
  - GAP: tx=1 for GAP_BITS bit-times, then done pulses -> IDLE.
- Latency: first start-bit edge on tx exactly 2 cycles after the accept edge. done occurs (10*N + GAP_BITS)*16*BR_LIMIT + 2 cycles after accept.
- Baud counter:
  - Free-runs only while not in IDLE/LOAD; cleared on entering START from LOAD.
  - Wraps at BR_LIMIT-1 to produce a tick; a 4-bit tick counter wraps at 15 to end a bit.
- tx is registered (glitch-free). In IDLE, cmd_valid held without acceptance has no effect on tx.
- cmd_valid asserted while busy: not accepted and not queued (cmd_ready=0).
- done and a new accept cannot coincide; cmd_ready rises the cycle after done.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - mode constants: MODE_SEND_TX=8'd64, MODE_SHOOTING_FLAGS=8'd65, MODE_AES_KEY=8'd66, MODE_AES_PT=8'd67.
  - FRAME_BYTES_MAX = MAX_PAYLOAD+2.
  - the state enum.
- Sub-module uart_byte_tx: byte in, 1-cycle start strobe, busy/byte_done, baud + bit counters, registered tx. uart_cmd_tx owns framing, index and gap.

Test Plan:
- BR_LIMIT=2 (bit=32 cycles); mode=8'h41, len=1, payload byte1=8'h43 -> tx bytes 41,43,41, each 320 cycles. done at 960+64+2=1026 cycles after accept; busy high throughout.
- mode=8'h42, len=16, payload bytes "0123456789abcdef" -> 18 bytes: 42, then 'f' down to '0', then 42. The decoded stream loopbacked into the badge receiver latches key = payload.
- cmd_len=0 and cmd_len=17 -> err one-cycle pulse, tx stays 1, busy stays 0, cmd_ready high again 2 cycles after accept.
- cmd_valid held and cmd_payload changed during transmission -> the frame still matches the latched values; a second command is accepted exactly 1 cycle after done.
- Assert reset_n=0 mid-DATA of byte 3 -> tx=1 and cmd_ready=1 asynchronously. After release, a new len=1 frame transmits correctly from its start bit.
- Bit timing check: measure every bit width over a 3-byte frame = 16*BR_LIMIT cycles exactly (BR_LIMIT=2 and BR_LIMIT=5).
